// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit order, the eight legal digit
// patterns (active-low, bit6..bit0 = g..a) and digit-strobe codes.
package seg7_pkg;

  typedef logic [6:0] seg_pat_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam seg_pat_t PAT_0     = 7'b1000000;
  localparam seg_pat_t PAT_1     = 7'b1111001;
  localparam seg_pat_t PAT_2     = 7'b0100100;
  localparam seg_pat_t PAT_3     = 7'b0110000;
  localparam seg_pat_t PAT_4     = 7'b0011001;
  localparam seg_pat_t PAT_5     = 7'b0010010;
  localparam seg_pat_t PAT_6     = 7'b0000010;
  localparam seg_pat_t PAT_7     = 7'b1111000;
  localparam seg_pat_t PAT_BLANK = 7'b1111111;

  localparam logic [1:0] AN_DIGIT0   = 2'b10;
  localparam logic [1:0] AN_DIGIT1   = 2'b01;
  localparam logic [1:0] AN_IDLE     = 2'b11;
  localparam logic [1:0] AN_CONFLICT = 2'b00;

  // Forward mapping for the display driver side.
  function automatic seg_pat_t seg7_encode(input logic [2:0] v);
    case (v)
      3'd0:    return PAT_0;
      3'd1:    return PAT_1;
      3'd2:    return PAT_2;
      3'd3:    return PAT_3;
      3'd4:    return PAT_4;
      3'd5:    return PAT_5;
      3'd6:    return PAT_6;
      default: return PAT_7;
    endcase
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from a raw segment pattern to its digit value;
// legal is low for anything outside the eight-entry table (blank included).
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [2:0] value,
  output logic       legal
);

  always_comb begin
    value = 3'd0;
    legal = 1'b1;
    case (pattern)
      PAT_0:   value = 3'd0;
      PAT_1:   value = 3'd1;
      PAT_2:   value = 3'd2;
      PAT_3:   value = 3'd3;
      PAT_4:   value = 3'd4;
      PAT_5:   value = 3'd5;
      PAT_6:   value = 3'd6;
      PAT_7:   value = 3'd7;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_readback.sv
// Reads back a two-digit multiplexed seven-segment bus and commits each digit
// only after STABLE consecutive identical strobed samples.
module seg7_readback
  import seg7_pkg::*;
#(
  parameter int STABLE = 4
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [1:0] an,
  output logic [2:0] value0,
  output logic [2:0] value1,
  output logic       valid0,
  output logic       valid1,
  output logic       upd0,
  output logic       upd1,
  output logic       bad_pat,
  output logic       bad_strobe
);

  localparam int             CW      = $clog2(STABLE + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE);

  logic [6:0] r_seg_q;
  logic [1:0] r_an_q;
  logic       r_bad_pat;
  logic       r_bad_strobe;

  logic [1:0] w_commit;
  logic [1:0] w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_q <= PAT_BLANK;
      r_an_q  <= AN_IDLE;
    end else begin
      r_seg_q <= seg;
      r_an_q  <= an;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_digit
    localparam logic [1:0] STROBE_CODE = (gi == 0) ? AN_DIGIT0 : AN_DIGIT1;

    logic [6:0]    r_cand;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_value;
    logic          r_valid;
    logic          r_upd;

    logic          w_strobe;
    logic          w_match;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    w_dec;

    seg7_pattern_decode u_decode (
      .pattern (r_seg_q),
      .value   (w_dec),
      .legal   (w_legal[gi])
    );

    assign w_strobe = (r_an_q == STROBE_CODE);
    assign w_match  = (r_seg_q == r_cand);

    always_comb begin
      if (!w_match)
        w_cnt_next = CW'(1);
      else if (r_cnt == CNT_MAX)
        w_cnt_next = CNT_MAX;
      else
        w_cnt_next = r_cnt + CW'(1);
    end

    // A mismatch that lands on CNT_MAX is a fresh run (only possible with STABLE=1).
    assign w_commit[gi] = w_strobe && (w_cnt_next == CNT_MAX) &&
                          (!w_match || (r_cnt != CNT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cand  <= PAT_BLANK;
        r_cnt   <= '0;
        r_value <= 3'd0;
        r_valid <= 1'b0;
        r_upd   <= 1'b0;
      end else begin
        r_upd <= 1'b0;
        if (w_strobe) begin
          r_cand <= r_seg_q;
          r_cnt  <= w_cnt_next;
        end
        if (w_commit[gi] && w_legal[gi]) begin
          r_value <= w_dec;
          r_valid <= 1'b1;
          r_upd   <= !r_valid || (w_dec != r_value);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bad_pat    <= 1'b0;
      r_bad_strobe <= 1'b0;
    end else begin
      r_bad_pat    <= |(w_commit & ~w_legal);
      r_bad_strobe <= (r_an_q == AN_CONFLICT);
    end
  end

  assign value0     = g_digit[0].r_value;
  assign value1     = g_digit[1].r_value;
  assign valid0     = g_digit[0].r_valid;
  assign valid1     = g_digit[1].r_valid;
  assign upd0       = g_digit[0].r_upd;
  assign upd1       = g_digit[1].r_upd;
  assign bad_pat    = r_bad_pat;
  assign bad_strobe = r_bad_strobe;

endmodule

// File: doc/seg7_readback.md
SEG7_READBACK -- requirements
Module: seg7_readback

Interface
REQ-001 SHALL have parameter STABLE, default 4, meaning the number of consecutive identical strobed samples required to commit a digit (legal range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port seg  input  7  segment lines, active-low, bit0=a(top), bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g(middle).
REQ-005 SHALL have port an  input  2  digit strobes, active-low; an[0] selects digit 0 (player 1), an[1] selects digit 1 (player 2).
REQ-006 SHALL have port value0 / value1  output  3 each  last committed decoded value of digit 0 / digit 1.
REQ-007 SHALL have port valid0 / valid1  output  1 each  high once the digit has committed at least one legal pattern.
REQ-008 SHALL have port upd0 / upd1  output  1 each  one-cycle pulse when the committed value changes or is first committed.
REQ-009 SHALL have port bad_pat  output  1  one-cycle pulse when a stable pattern outside the legal table commits.
REQ-010 SHALL have port bad_strobe  output  1  one-cycle pulse on every registered sample with an==2'b00.

Function
REQ-011 SHALL register seg and an once (seg_q, an_q); all decisions use the registered values only.
REQ-012 SHALL decode legal patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000 (bit6..bit0); every other pattern is illegal, including 1111111 (blank).
REQ-013 SHALL keep per digit a candidate pattern register (7 bits) and a saturating match counter of width $clog2(STABLE+1).
REQ-014 SHALL treat a sample as strobed for digit 0 only when an_q==2'b10 and for digit 1 only when an_q==2'b01.
REQ-015 SHALL, on a strobed sample equal to the candidate, increment the counter, saturating at STABLE.
REQ-016 SHALL, on a strobed sample differing from the candidate, load the candidate with seg_q and set the counter to 1.
REQ-017 SHALL leave candidate and counter unchanged on non-strobed samples (an_q==2'b11, the other digit's strobe, or 2'b00); gaps between strobes do not break stability.
REQ-018 SHALL commit on the edge where the counter transitions to STABLE (not while saturated); with STABLE=1 every pattern change commits on its first strobed sample.
REQ-019 SHALL, on a legal commit: update value, set valid, pulse upd on the same edge only if valid was 0 or the decoded value differs from value.
REQ-020 SHALL, on an illegal commit: hold value and valid unchanged, pulse bad_pat; if both digits commit illegal patterns on the same edge, bad_pat is a single pulse.
REQ-021 SHALL give a latency of STABLE+1 rising edges from a stable, continuously strobed input to the upd pulse and new value being visible.
REQ-022 SHALL treat an_q==2'b00 as a bus conflict: pulse bad_strobe, update neither digit.

Reset
REQ-023 SHALL, while rst_n is low, force seg_q=7'h7F, an_q=2'b11, candidates=7'h7F, counters=0, value0=value1=0, valid0=valid1=0, and all pulse outputs=0.
REQ-024 SHALL discard any partially accumulated match on reset mid-operation; the first commit after release requires a full STABLE-sample run.

Structure
REQ-025 SHALL place the eight legal pattern constants and the segment bit-order constants in the shared package seg7_pkg, used by both the display driver and this block.
REQ-026 SHALL implement pattern-to-value lookup as combinational sub-module seg7_pattern_decode (inputs pattern[6:0]; outputs value[2:0], legal), instantiated once per digit.

Verification
REQ-027 SHALL cover: STABLE=4, an=2'b10, seg=0100100 held -> value0=2, valid0=1, upd0 pulses exactly once, 5 edges after the change.
REQ-028 SHALL cover: digit 0 committed at 3, seg=0110000 re-presented for 10 samples -> no upd0 pulse; then 0011001 for 3 samples and back to 0110000 -> value0 stays 3, no upd0.
REQ-029 SHALL cover: alternating an=10/01 with seg 1111000 / 1000000, idle an=11 cycles between -> value0=7, value1=0, both upd pulses, no interference.
REQ-030 SHALL cover: stable seg=1111111 strobed on digit 1 -> one bad_pat pulse, value1/valid1 unchanged; an=2'b00 for 2 cycles -> two bad_strobe pulses, no counter change.
REQ-031 SHALL cover: rst_n low after 3 of 4 matching samples, release, then 3 more matches -> no commit; 4th match -> commit.
